// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver with a two-flop input synchroniser and mid-bit sampling.
// State and counters are exported for logic-analyser probing next to the transmitter.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 234,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  dato,
  output logic        dato_valido,
  output logic        error_trama,
  output logic        ocupado,
  output logic [2:0]  estado_rx,
  output logic [15:0] conta_rx,
  output logic [3:0]  conta_8_rx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATOS  = 3'd2,
    STOP   = 3'd3,
    ESPERA = 3'd4
  } state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  logic        rx_meta;
  logic        rx_s;
  state_t      state;
  state_t      state_next;
  logic [15:0] conta;
  logic [15:0] conta_next;
  logic [3:0]  conta_8;
  logic [3:0]  conta_8_next;
  logic [7:0]  shreg;
  logic [7:0]  shreg_next;
  logic [7:0]  dato_next;
  logic        valido_next;
  logic        error_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= ESPERA;
      conta       <= 16'd0;
      conta_8     <= 4'd0;
      shreg       <= 8'd0;
      dato        <= 8'd0;
      dato_valido <= 1'b0;
      error_trama <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      state       <= state_next;
      conta       <= conta_next;
      conta_8     <= conta_8_next;
      shreg       <= shreg_next;
      dato        <= dato_next;
      dato_valido <= valido_next;
      error_trama <= error_next;
    end
  end

  // The idle-state counter saturates so a long quiet line cannot wrap it.
  always_comb begin
    state_next   = state;
    conta_next   = (conta == 16'hFFFF) ? conta : conta + 16'd1;
    conta_8_next = conta_8;
    shreg_next   = shreg;
    dato_next    = dato;
    valido_next  = 1'b0;
    error_next   = 1'b0;

    case (state)
      ESPERA: begin
        if (rx_s) state_next = IDLE;
      end
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (conta == HALF_LAST) begin
          if (!rx_s) begin
            state_next   = DATOS;
            conta_8_next = 4'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATOS: begin
        if (conta == BIT_LAST) begin
          shreg_next   = {rx_s, shreg[7:1]};
          conta_8_next = conta_8 + 4'd1;
          if (conta_8 == 4'd7) state_next = STOP;
          else                 conta_next = 16'd0;
        end
      end
      STOP: begin
        if (conta == BIT_LAST) begin
          if (rx_s) begin
            dato_next   = shreg;
            valido_next = 1'b1;
            state_next  = IDLE;
          end else begin
            error_next = 1'b1;
            state_next = ESPERA;
          end
        end
      end
      default: state_next = ESPERA;
    endcase

    if (state_next != state) conta_next = 16'd0;
  end

  assign ocupado    = (state == START) || (state == DATOS) || (state == STOP);
  assign estado_rx  = state;
  assign conta_rx   = conta;
  assign conta_8_rx = conta_8;

endmodule
